// File: rtl/button_pkg.sv
// button_pkg
//   Shared definitions for the push-button conditioner:
//   - default debounce / hold / repeat timing constants
//   - the per-channel FSM state encoding
//   - a packed debug view of all three channels (states + debounced levels)
//   - helper that sizes the per-channel counter
package button_pkg;

  localparam int         DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int         DEFAULT_HOLD_CYCLES     = 250;
  localparam int         DEFAULT_REPEAT_CYCLES   = 50;
  localparam logic [2:0] DEFAULT_REPEAT_EN       = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } btn_state_e;

  typedef struct packed {
    btn_state_e soma;
    btn_state_e subtracao;
    btn_state_e cont;
    logic [2:0] level;   // {cont, subtracao, soma} debounced levels
  } btn_dbg_t;

  // Counter width: clog2 of the largest timing parameter, never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel
//   One push-button channel: 2-FF synchronizer, debounce/hold/repeat FSM with
//   a single counter, and a registered one-cycle pulse plus debounced level.
//
//   Ports:
//     clock    - system clock, rising edge
//     reset    - asynchronous, active-low
//     btn_raw  - raw bouncing button level (asynchronous)
//     pulse    - one-cycle press / auto-repeat pulse (registered)
//     level    - debounced level: 1 in HELD, REPEAT, RELEASE_DB (registered)
//     state    - current FSM state, for debug visibility
//
//   DEBOUNCE_CYCLES must be at least 2; HOLD_CYCLES and REPEAT_CYCLES at
//   least 2 so pulses are never adjacent.
module button_channel import button_pkg::*; #(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int   REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter logic REPEAT_EN       = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       pulse,
  output logic       level,
  output btn_state_e state
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

  // The sample that moves IDLE->PRESS_DB (or HELD->RELEASE_DB) is the first
  // of the debounce window, so the counter only has to cover the remaining
  // DEBOUNCE_CYCLES-1 samples: it qualifies on reaching DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             sync;

  assign sync = sync2_q;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sync) begin
          state_d = ST_PRESS_DB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Without auto-repeat the counter parks at HOLD_LAST.
          if (REPEAT_EN) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!sync) begin
          state_d = ST_RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        // A bounce back to 1 restarts the hold timer from zero.
        if (sync) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Level is registered from the next state so it tracks state_q exactly.
  always_comb begin
    level_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
              (state_d == ST_RELEASE_DB);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign state = state_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Three independent button channels (soma, subtracao, cont) producing
//   one-cycle pulses for the clock/display block.
//
//   Ports:
//     clock, reset                     - system clock; async active-low reset
//     soma_raw, subtracao_raw, cont_raw - raw bouncing button levels
//     soma, subtracao, cont            - one-cycle pulses
//     cont_level                       - debounced level of the cont button
//     dbg_state                        - FSM states and levels of all channels
//
//   soma and subtracao are mutually exclusive: if both channels pulse in the
//   same cycle, neither is forwarded (the channel FSMs are unaffected).
module button_conditioner import button_pkg::*; #(
  parameter int         DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int         HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int         REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter logic [2:0] REPEAT_EN       = DEFAULT_REPEAT_EN
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     soma_raw,
  input  logic     subtracao_raw,
  input  logic     cont_raw,
  output logic     soma,
  output logic     subtracao,
  output logic     cont,
  output logic     cont_level,
  output btn_dbg_t dbg_state
);

  logic       soma_pulse, sub_pulse, cont_pulse;
  logic [2:0] level;
  btn_state_e soma_st, sub_st, cont_st;

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN[0])
  ) u_soma (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (soma_raw),
    .pulse   (soma_pulse),
    .level   (level[0]),
    .state   (soma_st)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN[1])
  ) u_subtracao (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (subtracao_raw),
    .pulse   (sub_pulse),
    .level   (level[1]),
    .state   (sub_st)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN[2])
  ) u_cont (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (cont_raw),
    .pulse   (cont_pulse),
    .level   (level[2]),
    .state   (cont_st)
  );

  // Gating registered pulses only: still no path from any raw input.
  assign soma       = soma_pulse & ~sub_pulse;
  assign subtracao  = sub_pulse & ~soma_pulse;
  assign cont       = cont_pulse;
  assign cont_level = level[2];

  assign dbg_state = '{soma: soma_st, subtracao: sub_st, cont: cont_st,
                       level: level};

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with default parameters.
//   A window/elapsed-time model predicts every output each cycle; directed
//   scenarios also check pulse counts and timings against literal values.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int D = 4;
  localparam int H = 250;
  localparam int R = 50;

  // ---------------- clock / reset ----------------
  logic     clock;
  logic     reset;
  logic     soma_raw, subtracao_raw, cont_raw;
  logic     soma, subtracao, cont, cont_level;
  btn_dbg_t dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  button_conditioner dut (
    .clock         (clock),
    .reset         (reset),
    .soma_raw      (soma_raw),
    .subtracao_raw (subtracao_raw),
    .cont_raw      (cont_raw),
    .soma          (soma),
    .subtracao     (subtracao),
    .cont          (cont),
    .cont_level    (cont_level),
    .dbg_state     (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Sync sample seen at an edge = raw captured two edges earlier. A press is
  // qualified by D consecutive 1 samples, a release by D consecutive 0s.
  // While pressed, pulses fall at elapsed times H, H+R, H+2R... counted from
  // the press (or from the last bounce back to 1).
  bit [2:0] m_ren = 3'b011;
  int       m_ones[3]  = '{0, 0, 0};
  int       m_zeros[3] = '{0, 0, 0};
  int       m_t0[3]    = '{0, 0, 0};
  bit       m_lvl[3]   = '{0, 0, 0};
  bit       m_d0[3]    = '{0, 0, 0};
  bit       m_d1[3]    = '{0, 0, 0};
  bit       m_p[3]     = '{0, 0, 0};
  bit [2:0] m_raw;
  bit       m_s;
  int       m_t;
  int       edge_n = 0;
  logic     exp_soma = 1'b0, exp_sub = 1'b0, exp_cont = 1'b0, exp_lvl = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        m_ones[c] = 0; m_zeros[c] = 0; m_t0[c] = 0;
        m_lvl[c] = 1'b0; m_d0[c] = 1'b0; m_d1[c] = 1'b0; m_p[c] = 1'b0;
      end
      edge_n = 0;
      exp_soma = 1'b0; exp_sub = 1'b0; exp_cont = 1'b0; exp_lvl = 1'b0;
    end else begin
      edge_n++;
      m_raw = {cont_raw, subtracao_raw, soma_raw};
      for (int c = 0; c < 3; c++) begin
        m_s = m_d1[c];
        m_d1[c] = m_d0[c];
        m_d0[c] = m_raw[c];
        m_p[c] = 1'b0;
        if (m_s) begin m_ones[c]++; m_zeros[c] = 0; end
        else begin m_zeros[c]++; m_ones[c] = 0; end
        if (!m_lvl[c]) begin
          if (m_ones[c] == D) begin
            m_lvl[c] = 1'b1; m_p[c] = 1'b1; m_t0[c] = edge_n;
          end
        end else if (m_zeros[c] == D) begin
          m_lvl[c] = 1'b0;
        end else if (m_s) begin
          if (m_ones[c] == 1) m_t0[c] = edge_n;
          m_t = edge_n - m_t0[c];
          if (m_ren[c] && m_t >= H && ((m_t - H) % R) == 0) m_p[c] = 1'b1;
        end
      end
      exp_soma = m_p[0] & ~m_p[1];
      exp_sub  = m_p[1] & ~m_p[0];
      exp_cont = m_p[2];
      exp_lvl  = m_lvl[2];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_soma",       soma,       exp_soma);
      check("model_subtracao",  subtracao,  exp_sub);
      check("model_cont",       cont,       exp_cont);
      check("model_cont_level", cont_level, exp_lvl);
    end
  end

  // ---------------- directed observation ----------------
  int   step = 0;
  int   soma_q[$], sub_q[$], cont_q[$];
  int   lvl_rise, lvl_fall;
  bit   lvl_seen;
  logic prev_lvl = 1'b0;

  task automatic clear_logs();
    soma_q.delete(); sub_q.delete(); cont_q.delete();
    lvl_rise = -1; lvl_fall = -1; lvl_seen = 1'b0;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      step++;
      if (soma)      soma_q.push_back(step);
      if (subtracao) sub_q.push_back(step);
      if (cont)      cont_q.push_back(step);
      if (cont_level) lvl_seen = 1'b1;
      if (cont_level && !prev_lvl) lvl_rise = step;
      if (!cont_level && prev_lvl) lvl_fall = step;
      prev_lvl = cont_level;
    end
  endtask

  function automatic int at(input int q[$], input int idx, input int base);
    if (idx < q.size()) return q[idx] - base;
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  int base;
  int rel_release;

  initial begin
    reset = 1'b1;
    soma_raw = 1'b0; subtracao_raw = 1'b0; cont_raw = 1'b0;
    clear_logs();
    #3 reset = 1'b0;

    // Reset state
    watch(3);
    check("rst_soma",       soma,       0);
    check("rst_subtracao",  subtracao,  0);
    check("rst_cont",       cont,       0);
    check("rst_cont_level", cont_level, 0);
    check("rst_state_soma", int'(dbg_state.soma),      int'(ST_IDLE));
    check("rst_state_sub",  int'(dbg_state.subtracao), int'(ST_IDLE));
    check("rst_state_cont", int'(dbg_state.cont),      int'(ST_IDLE));
    #1 reset = 1'b1;
    chk_en = 1'b1;
    watch(2);

    // Single press: one pulse, 6 edges after the first sampling edge
    clear_logs(); base = step;
    soma_raw = 1'b1; watch(20);
    soma_raw = 1'b0; watch(12);
    check("press_count",     soma_q.size(), 1);
    check("press_latency",   at(soma_q, 0, base), 6);
    check("press_sub_quiet", sub_q.size(), 0);
    check("press_cont_quiet", cont_q.size(), 0);

    // Short bursts never qualify
    clear_logs();
    for (int b = 0; b < 5; b++) begin
      cont_raw = 1'b1; watch(3);
      cont_raw = 1'b0; watch(3);
    end
    watch(10);
    check("burst_cont_count", cont_q.size(), 0);
    check("burst_cont_level", int'(lvl_seen), 0);

    // Long soma hold: press, +250, then every 50
    clear_logs(); base = step;
    soma_raw = 1'b1; watch(400);
    soma_raw = 1'b0; watch(20);
    check("repeat_count", soma_q.size(), 4);
    check("repeat_t0",    at(soma_q, 0, base), 6);
    check("repeat_t1",    at(soma_q, 1, base), 256);
    check("repeat_t2",    at(soma_q, 2, base), 306);
    check("repeat_t3",    at(soma_q, 3, base), 356);

    // Long cont hold: no auto-repeat, level window
    clear_logs(); base = step;
    cont_raw = 1'b1; watch(400);
    cont_raw = 1'b0; rel_release = step; watch(20);
    check("cont_hold_count", cont_q.size(), 1);
    check("cont_hold_t0",    at(cont_q, 0, base), 6);
    check("cont_level_rise", lvl_rise - base, 6);
    check("cont_level_fall", lvl_fall - rel_release, 6);

    // Simultaneous soma/subtracao: both suppressed, FSMs still advance
    clear_logs();
    soma_raw = 1'b1; subtracao_raw = 1'b1; watch(20);
    check("conflict_soma",     soma_q.size(), 0);
    check("conflict_sub",      sub_q.size(), 0);
    check("conflict_st_soma",  int'(dbg_state.soma),      int'(ST_HELD));
    check("conflict_st_sub",   int'(dbg_state.subtracao), int'(ST_HELD));
    check("conflict_levels",   int'(dbg_state.level), 3);
    soma_raw = 1'b0; subtracao_raw = 1'b0; watch(12);

    // Release bounce during hold restarts the hold timer
    clear_logs(); base = step;
    subtracao_raw = 1'b1; watch(100);
    subtracao_raw = 1'b0; watch(2);
    subtracao_raw = 1'b1; watch(298);
    subtracao_raw = 1'b0; watch(20);
    check("bounce_count", sub_q.size(), 2);
    check("bounce_t0",    at(sub_q, 0, base), 6);
    check("bounce_t1",    at(sub_q, 1, base), 355);

    // Reset mid-press: no pulse, then a fresh press after release of reset
    clear_logs();
    soma_raw = 1'b1; watch(5);
    #1 reset = 1'b0;
    watch(3);
    check("midreset_no_pulse", soma_q.size(), 0);
    #1 reset = 1'b1;
    base = step;
    watch(10);
    check("midreset_count",   soma_q.size(), 1);
    check("midreset_latency", at(soma_q, 0, base), 6);
    soma_raw = 1'b0; watch(12);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
